// File: rtl/keypad_emulator.sv
// 3x4 phone keypad emulator: accepts key codes over valid/ready, plays a press
// with contact bounce, and answers the peripheral's row scan on the column lines.
module keypad_emulator #(
  parameter logic [15:0] HOLD_CYCLES   = 16'd1000,
  parameter logic [15:0] BOUNCE_CYCLES = 16'd200,
  parameter logic [15:0] BOUNCE_PERIOD = 16'd10,
  parameter logic [15:0] GAP_CYCLES    = 16'd500
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       B,
  input  logic       G,
  input  logic       F,
  input  logic       D,
  output logic       C,
  output logic       A,
  output logic       E,
  input  logic [3:0] KEY_CODE,
  input  logic       KEY_VALID,
  output logic       KEY_READY,
  output logic       PRESSED,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {IDLE, BNC_IN, HOLD, BNC_OUT, GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tog_q, tog_d;
  logic        contact_q, contact_d;
  logic [1:0]  key_row_q, key_row_d;
  logic [1:0]  key_col_q, key_col_d;
  logic [2:0]  col_q, col_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [3:0]  rows;
  logic [3:0]  dec;
  logic        code_ok;
  logic        bnc_last, hold_last, gap_last, tog_last;

  assign rows = {D, F, G, B};

  // {row, col} of each legal key code
  always_comb begin
    dec = 4'b0000;
    case (KEY_CODE)
      4'd0:  dec = 4'b1101;
      4'd1:  dec = 4'b0000;
      4'd2:  dec = 4'b0001;
      4'd3:  dec = 4'b0010;
      4'd4:  dec = 4'b0100;
      4'd5:  dec = 4'b0101;
      4'd6:  dec = 4'b0110;
      4'd7:  dec = 4'b1000;
      4'd8:  dec = 4'b1001;
      4'd9:  dec = 4'b1010;
      4'd10: dec = 4'b1100;
      4'd11: dec = 4'b1110;
      default: dec = 4'b0000;
    endcase
  end

  assign code_ok = (KEY_CODE <= 4'd11);

  // 17-bit compares so a zero-length phase ends after its first cycle without wrapping
  assign bnc_last  = ({1'b0, cnt_q} + 17'd1) >= {1'b0, BOUNCE_CYCLES};
  assign hold_last = ({1'b0, cnt_q} + 17'd1) >= {1'b0, HOLD_CYCLES};
  assign gap_last  = ({1'b0, cnt_q} + 17'd1) >= {1'b0, GAP_CYCLES};
  assign tog_last  = ({1'b0, tog_q} + 17'd1) >= {1'b0, BOUNCE_PERIOD};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    tog_d     = 16'd0;
    contact_d = contact_q;
    key_row_d = key_row_q;
    key_col_d = key_col_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (KEY_VALID) begin
          if (code_ok) begin
            contact_d = 1'b1;
            key_row_d = dec[3:2];
            key_col_d = dec[1:0];
            state_d   = (BOUNCE_CYCLES == 16'd0) ? HOLD : BNC_IN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BNC_IN, BNC_OUT: begin
        tog_d = tog_q + 16'd1;
        if (bnc_last) begin
          contact_d = (state_q == BNC_IN);
          state_d   = (state_q == BNC_IN) ? HOLD : GAP;
          cnt_d     = 16'd0;
          tog_d     = 16'd0;
        end else if (tog_last) begin
          contact_d = ~contact_q;
          tog_d     = 16'd0;
        end
      end
      HOLD: begin
        if (hold_last) begin
          contact_d = 1'b0;
          state_d   = (BOUNCE_CYCLES == 16'd0) ? GAP : BNC_OUT;
          cnt_d     = 16'd0;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
        cnt_d     = 16'd0;
      end
    endcase
    // columns follow the next contact state so they line up with PRESSED
    col_d = {3{contact_d & rows[key_row_d]}} & (3'b001 << key_col_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      tog_q     <= 16'd0;
      contact_q <= 1'b0;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      col_q     <= 3'b000;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      contact_q <= contact_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      col_q     <= col_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign C         = col_q[0];
  assign A         = col_q[1];
  assign E         = col_q[2];
  assign PRESSED   = contact_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign KEY_READY = (state_q == IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: per-cycle expected press traces are queued
// at stimulus time and popped against the DUT on each falling edge.
module tb_keypad_emulator;
  localparam int HOLD = 8, BC = 4, BP = 1, GAPC = 3;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic [3:0] rows = 4'b0000;  // {D,F,G,B}
  logic       B, G, F, D, C, A, E;
  logic [3:0] key_code = 4'd0;
  logic       key_valid = 1'b0;
  logic       key_ready, pressed, done, err;

  int checks = 0, failures = 0;

  typedef struct packed {
    logic       p;
    logic [2:0] col;
    logic       done;
    logic       rdy;
  } exp_t;
  exp_t exp_q[$];

  assign {D, F, G, B} = rows;

  keypad_emulator #(.HOLD_CYCLES(16'd8), .BOUNCE_CYCLES(16'd4),
                    .BOUNCE_PERIOD(16'd1), .GAP_CYCLES(16'd3)) dut (
    .CLK(CLK), .RST_N(RST_N), .B(B), .G(G), .F(F), .D(D),
    .C(C), .A(A), .E(E), .KEY_CODE(key_code), .KEY_VALID(key_valid),
    .KEY_READY(key_ready), .PRESSED(pressed), .DONE(done), .ERR(err));

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int key_col(input int code);
    if (code == 0) return 1;
    if (code == 10) return 0;
    if (code == 11) return 2;
    return (code - 1) % 3;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit p, input int n, input int kc,
                              input bit hit0, input bit hit1, input int sw);
    exp_t e;
    bit   hit = (n >= sw) ? hit1 : hit0;
    e.p    = p;
    e.col  = (p && hit) ? (3'b001 << kc) : 3'b000;
    e.done = 1'b0;
    e.rdy  = 1'b0;
    return e;
  endfunction

  // Expected trace from the first BNC_IN cycle through the IDLE cycle carrying DONE
  task automatic push_press(input int code, input bit hit0, input bit hit1, input int sw);
    int   n = 0;
    int   kc = key_col(code);
    exp_t e;
    for (int i = 0; i < BC; i++)   begin exp_q.push_back(mk(((i / BP) % 2) == 0, n, kc, hit0, hit1, sw)); n++; end
    for (int i = 0; i < HOLD; i++) begin exp_q.push_back(mk(1'b1, n, kc, hit0, hit1, sw)); n++; end
    for (int i = 0; i < BC; i++)   begin exp_q.push_back(mk(((i / BP) % 2) == 1, n, kc, hit0, hit1, sw)); n++; end
    for (int i = 0; i < GAPC; i++) begin exp_q.push_back(mk(1'b0, n, kc, hit0, hit1, sw)); n++; end
    e = '{p: 1'b0, col: 3'b000, done: 1'b1, rdy: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic run_trace(input int sw, input logic [3:0] new_rows,
                           input int offer_at, input int offer_code);
    int   n = 0;
    exp_t e;
    while (exp_q.size() > 0 && n < 200) begin
      e = exp_q.pop_front();
      chk("pressed", {3'b0, pressed}, {3'b0, e.p});
      chk("cols_EAC", {1'b0, E, A, C}, {1'b0, e.col});
      chk("done", {3'b0, done}, {3'b0, e.done});
      chk("ready", {3'b0, key_ready}, {3'b0, e.rdy});
      chk("err", {3'b0, err}, 4'h0);
      if (n == 0) key_valid = 1'b0;
      n++;
      if (n == sw) rows = new_rows;
      if (n == offer_at) begin key_code = offer_code[3:0]; key_valid = 1'b1; end
      @(negedge CLK);
    end
  endtask

  task automatic start_press(input int code);
    chk("ready_before_accept", {3'b0, key_ready}, 4'h1);
    key_code  = code[3:0];
    key_valid = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    // 1: reset state
    @(negedge CLK);
    chk("rst_cols", {1'b0, E, A, C}, 4'h0);
    chk("rst_pressed", {3'b0, pressed}, 4'h0);
    chk("rst_ready", {3'b0, key_ready}, 4'h1);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_flags", {1'b0, pressed, done, err}, 4'h0);
    chk("post_rst_cols", {1'b0, E, A, C}, 4'h0);
    chk("post_rst_ready", {3'b0, key_ready}, 4'h1);

    // 2: code 5 with G held high
    rows = 4'b0010;
    start_press(5);
    push_press(5, 1'b1, 1'b1, 1000);
    run_trace(1000, 4'b0000, -1, 0);
    chk("t2_done_cleared", {3'b0, done}, 4'h0);
    chk("t2_ready", {3'b0, key_ready}, 4'h1);

    // 3: code 11, only B high, switch to D mid-HOLD
    rows = 4'b0001;
    start_press(11);
    push_press(11, 1'b0, 1'b1, BC + 3);
    run_trace(BC + 3, 4'b1000, -1, 0);

    // 4: invalid code 13
    key_code = 4'd13; key_valid = 1'b1;
    @(negedge CLK);
    chk("t4_err", {3'b0, err}, 4'h1);
    chk("t4_ready", {3'b0, key_ready}, 4'h1);
    chk("t4_pressed", {3'b0, pressed}, 4'h0);
    key_valid = 1'b0;
    @(negedge CLK);
    chk("t4_err_gone", {3'b0, err}, 4'h0);
    chk("t4_ready_after", {3'b0, key_ready}, 4'h1);

    // 5: code 1, code 9 offered during HOLD is held off until IDLE
    rows = 4'b0101;
    start_press(1);
    push_press(1, 1'b1, 1'b1, 1000);
    run_trace(1000, 4'b0000, BC + 2, 9);
    push_press(9, 1'b1, 1'b1, 1000);
    run_trace(1000, 4'b0000, -1, 0);

    // 6: code 0 with D high, async reset during HOLD
    rows = 4'b1000;
    start_press(0);
    key_valid = 1'b0;
    repeat (BC + 2) @(negedge CLK);
    chk("t6_pressed_hold", {3'b0, pressed}, 4'h1);
    chk("t6_cols_hold", {1'b0, E, A, C}, 4'h2);
    RST_N = 1'b0;
    #1;
    chk("t6_pressed_async", {3'b0, pressed}, 4'h0);
    chk("t6_cols_async", {1'b0, E, A, C}, 4'h0);
    chk("t6_ready_async", {3'b0, key_ready}, 4'h1);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("t6_no_done", {2'b0, done, pressed}, 4'h0);
      chk("t6_ready_idle", {3'b0, key_ready}, 4'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
